// File: rtl/adder_bist_pkg.sv
// adder_bist shared definitions.
// FSM encoding and default sizing.
package adder_bist_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_ERR_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_bist_pipe.sv
// adder_bist golden delay line.
// LATENCY-deep shift of {valid, A, B, exp_ovf, exp_sum}.
module adder_bist_pipe
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ovf,
  input  logic [WIDTH-1:0] sum,
  output logic             v_q,
  output logic [WIDTH-1:0] a_q,
  output logic [WIDTH-1:0] b_q,
  output logic             ovf_q,
  output logic [WIDTH-1:0] sum_q
);

  localparam int PW = 3 * WIDTH + 2;

  logic [PW-1:0] q [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++)
        q[i] <= '0;
    end else begin
      q[0] <= {push, a, b, ovf, sum};
      for (int i = 1; i < LATENCY; i++)
        q[i] <= q[i-1];
    end
  end

  assign {v_q, a_q, b_q, ovf_q, sum_q} = q[LATENCY-1];

endmodule

// File: rtl/adder_bist.sv
// adder_bist: exhaustive stimulus/check engine
// for a registered WIDTH-bit adder.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic             En_out,
  input  logic [WIDTH-1:0] Sum_in,
  input  logic             Overflow_in,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] Err_cnt,
  output logic [WIDTH-1:0] Fail_A,
  output logic [WIDTH-1:0] Fail_B
);

  localparam int IW = 2 * WIDTH + 1;
  localparam int FW = $clog2(LATENCY + 1) + 1;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [FW-1:0]   fcnt;
  logic [WIDTH:0]  gold;

  logic             p_v;
  logic [WIDTH-1:0] p_a;
  logic [WIDTH-1:0] p_b;
  logic             p_ovf;
  logic [WIDTH-1:0] p_sum;
  logic             mism;
  logic             sat;

  assign gold = {1'b0, A_out} + {1'b0, B_out};

  adder_bist_pipe #(
    .WIDTH  (WIDTH),
    .LATENCY(LATENCY)
  ) u_pipe (
    .clk  (Clk),
    .rst_n(Rst_n),
    .push (En_out),
    .a    (A_out),
    .b    (B_out),
    .ovf  (gold[WIDTH]),
    .sum  (gold[WIDTH-1:0]),
    .v_q  (p_v),
    .a_q  (p_a),
    .b_q  (p_b),
    .ovf_q(p_ovf),
    .sum_q(p_sum)
  );

  assign mism = p_v &&
    ({Overflow_in, Sum_in} != {p_ovf, p_sum});
  assign sat  = &Err_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      fcnt    <= '0;
      A_out   <= '0;
      B_out   <= '0;
      En_out  <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Pass    <= 1'b0;
      Err_cnt <= '0;
      Fail_A  <= '0;
      Fail_B  <= '0;
    end else begin
      // Err_cnt is still zero only before the first miss
      if (mism) begin
        if (!sat)
          Err_cnt <= Err_cnt + 1'b1;
        if (Err_cnt == '0) begin
          Fail_A <= p_a;
          Fail_B <= p_b;
        end
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state          <= S_DRIVE;
            {A_out, B_out} <= '0;
            idx            <= IW'(1);
            En_out         <= 1'b1;
            Busy           <= 1'b1;
            Done           <= 1'b0;
            Pass           <= 1'b0;
            Err_cnt        <= '0;
            Fail_A         <= '0;
            Fail_B         <= '0;
          end
        end
        S_DRIVE: begin
          if (idx[IW-1]) begin
            state  <= S_FLUSH;
            En_out <= 1'b0;
            fcnt   <= '0;
          end else begin
            {A_out, B_out} <= idx[IW-2:0];
            idx            <= idx + 1'b1;
          end
        end
        S_FLUSH: begin
          // one extra edge lets the last compare land in Err_cnt
          if (fcnt == FW'(LATENCY)) begin
            state <= S_DONE;
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Pass  <= (Err_cnt == '0);
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist paired
// with a behavioural registered adder.
module tb_adder_bist;

  localparam int W    = 4;
  localparam int LAT  = 1;
  localparam int EW   = 16;
  localparam int NV   = 1 << (2 * W);
  localparam int DEDG = NV + LAT + 1;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          Start = 1'b0;
  logic [W-1:0]  A_out, B_out, Sum_in;
  logic [W-1:0]  Fail_A, Fail_B;
  logic          En_out, Overflow_in;
  logic          Busy, Done, Pass;
  logic [EW-1:0] Err_cnt;

  int tests = 0;
  int fails = 0;

  always #100 Clk = ~Clk;

  adder_bist #(
    .WIDTH  (W),
    .LATENCY(LAT),
    .ERR_W  (EW)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Start      (Start),
    .A_out      (A_out),
    .B_out      (B_out),
    .En_out     (En_out),
    .Sum_in     (Sum_in),
    .Overflow_in(Overflow_in),
    .Busy       (Busy),
    .Done       (Done),
    .Pass       (Pass),
    .Err_cnt    (Err_cnt),
    .Fail_A     (Fail_A),
    .Fail_B     (Fail_B)
  );

  // registered adder with fault injection
  int           mode = 0;
  logic [W:0]   xmask [NV];
  logic [W-1:0] ar, br;
  logic [W:0]   sr, so;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ar <= '0; br <= '0; sr <= '0;
    end else if (En_out) begin
      ar <= A_out;
      br <= B_out;
      sr <= {1'b0, A_out} + {1'b0, B_out};
    end
  end

  always_comb begin
    so = sr ^ xmask[{ar, br}];
    case (mode)
      1: so[0] = 1'b0;
      2: so[W] = 1'b0;
      3: so[3] = 1'b1;
      4: so[W] = 1'b1;
      default: ;
    endcase
  end

  assign Sum_in      = so[W-1:0];
  assign Overflow_in = so[W];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // One sweep from a Start pulse; samples 1 time unit
  // after each edge, edge 0 being the Start edge.
  task automatic sweep(input int poke,
                       output int dedge,
                       output int busyc,
                       output int enc,
                       output bit seq_ok);
    int n;
    int k;
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start  = 1'b0;
    n      = 0;
    k      = 0;
    dedge  = -1;
    busyc  = 0;
    enc    = 0;
    seq_ok = 1'b1;
    while (dedge < 0 && n <= NV + 50) begin
      if (Busy) busyc++;
      if (En_out) begin
        if ({A_out, B_out} != k[2*W-1:0]) seq_ok = 1'b0;
        k++;
        enc++;
      end
      if (Done) dedge = n;
      if (poke == 1)
        Start = (n == 50 || n == NV || n == NV + 1);
      else if (poke == 2)
        Start = (n < DEDG - 1) && ($urandom_range(0, 7) == 0);
      else
        Start = 1'b0;
      if (dedge < 0) begin
        @(posedge Clk);
        #1;
        n++;
      end
    end
    Start = 1'b0;
  endtask

  task automatic check_sweep(input string tg,
                             input int poke,
                             input int eerr,
                             input int efirst);
    int  de, bc, ec;
    bit  sq;
    sweep(poke, de, bc, ec, sq);
    chk({tg, "_done_edge"}, de, DEDG);
    chk({tg, "_busy_cycles"}, bc, DEDG);
    chk({tg, "_en_cycles"}, ec, NV);
    chk({tg, "_vec_order"}, sq, 1);
    chk({tg, "_err_cnt"}, Err_cnt, eerr);
    chk({tg, "_pass"}, Pass, (eerr == 0));
    if (eerr != 0) begin
      chk({tg, "_fail_a"}, Fail_A, efirst >> W);
      chk({tg, "_fail_b"}, Fail_B, efirst % (1 << W));
    end
    repeat (3) @(posedge Clk);
    #1;
    chk({tg, "_done_held"}, {Done, Busy, En_out}, 3'b100);
  endtask

  typedef struct {
    int md;
    int err;
    int first;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int n;
    int nbad;
    int first;
    int cnt;

    for (int i = 0; i < NV; i++) xmask[i] = '0;
    tbl[0] = '{0, 0,   0};
    tbl[1] = '{1, 128, 1};
    tbl[2] = '{0, 0,   0};
    tbl[3] = '{2, 120, 16 + 15};
    tbl[4] = '{3, 128, 0};
    tbl[5] = '{4, 136, 0};

    #1;
    chk("reset_outs",
        {A_out, B_out, En_out, Busy, Done, Pass,
         Err_cnt, Fail_A, Fail_B}, 0);
    #300;
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("idle_outs", {En_out, Busy, Done, Pass}, 0);

    // fault table; entries 1->2 exercise restart from DONE
    for (int i = 0; i < 6; i++) begin
      mode = tbl[i].md;
      check_sweep($sformatf("tbl%0d", i), 0,
                  tbl[i].err, tbl[i].first);
    end
    mode = 0;

    // Start during DRIVE and FLUSH must be ignored
    check_sweep("poke", 1, 0, 0);

    // reset in the middle of a sweep
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n = 0;
    while ({A_out, B_out} != 8'd100 && n < 400) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("rst_reach_vec100", {A_out, B_out}, 100);
    #50;
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_outs",
        {A_out, B_out, En_out, Busy, Done, Pass,
         Err_cnt, Fail_A, Fail_B}, 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_no_done", {Busy, Done}, 0);
    check_sweep("post_rst", 0, 0, 0);

    // random corruption sets, reference from plain counting
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NV; i++) xmask[i] = '0;
      nbad = (r == 0) ? 1 : $urandom_range(0, 20);
      for (int j = 0; j < nbad; j++)
        xmask[$urandom_range(0, NV - 1)] =
          (W + 1)'($urandom_range(1, (1 << (W + 1)) - 1));
      cnt   = 0;
      first = -1;
      for (int i = 0; i < NV; i++)
        if (xmask[i] != '0) begin
          cnt++;
          if (first < 0) first = i;
        end
      check_sweep($sformatf("rnd%0d", r), 2, cnt, first);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
